// File: rtl/td4_ctrl_pkg.sv
// Shared definitions for the TD4 execution controller: state encoding,
// the JMP opcode nibble and the self-jump detector.
package td4_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_BRK  = 2'd2,
        ST_SPIN = 2'd3
    } exec_state_t;

    localparam logic [3:0] OP_JMP = 4'b1111;

    // An unconditional JMP whose target is its own address never leaves.
    function automatic logic is_self_jump(input logic [7:0] opcode, input logic [3:0] pc);
        return (opcode[7:4] == OP_JMP) && (opcode[3:0] == pc);
    endfunction

endpackage

// File: rtl/td4_debounce.sv
// Conditions one active-low board input: inversion, 2-flop synchronizer,
// stability-count debouncer and a one-cycle pulse on the debounced rising edge.
module td4_debounce #(
    parameter int DEB_CYCLES = 240_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    // The level only follows the synchronized input once it has disagreed
    // with the current level for DEB_CYCLES consecutive samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            rise       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_a  <= ~raw_n;
            sync_b  <= sync_a;
            level_d <= level;
            rise    <= level & ~level_d;
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 execution controller: turns the RUN switch, STEP button, PC breakpoint
// and self-jump detection into a single-cycle execute enable for the core.
module td4_exec_ctrl
    import td4_ctrl_pkg::*;
#(
    parameter int DIV        = 24_000_000,
    parameter int DEB_CYCLES = 240_000,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_sw_n,
    input  logic             step_btn_n,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    input  logic [3:0]       pc,
    input  logic [7:0]       opcode,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic             brk_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TICK_W = $clog2(DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);

    exec_state_t       state_q;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              bp_skip;
    logic              run_lvl;
    logic              run_rise_unused;
    logic              step_lvl_unused;
    logic              step_pulse;

    td4_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
        .clock (clock),
        .reset (reset),
        .raw_n (run_sw_n),
        .level (run_lvl),
        .rise  (run_rise_unused)
    );

    td4_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clock (clock),
        .reset (reset),
        .raw_n (step_btn_n),
        .level (step_lvl_unused),
        .rise  (step_pulse)
    );

    assign tick   = (tick_cnt == TICK_LAST);
    assign state  = state_q;
    assign halted = (state_q != ST_RUN);

    // A falling run level always wins; a breakpoint at the PC we resumed from
    // is skipped once so that RUN can leave it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HALT;
            cpu_en      <= 1'b0;
            brk_hit     <= 1'b0;
            bp_skip     <= 1'b0;
            tick_cnt    <= '0;
            instr_count <= '0;
        end else begin
            cpu_en <= 1'b0;
            if (cpu_en) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            case (state_q)
                ST_HALT: begin
                    if (run_lvl) begin
                        state_q  <= ST_RUN;
                        tick_cnt <= '0;
                        bp_skip  <= 1'b1;
                        brk_hit  <= 1'b0;
                    end else if (step_pulse) begin
                        cpu_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_lvl) begin
                        state_q <= ST_HALT;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        if (bp_en && (pc == bp_addr) && !bp_skip) begin
                            state_q <= ST_BRK;
                            brk_hit <= 1'b1;
                        end else if (is_self_jump(opcode, pc)) begin
                            state_q <= ST_SPIN;
                        end else begin
                            cpu_en  <= 1'b1;
                            bp_skip <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                ST_BRK: begin
                    if (!run_lvl) begin
                        state_q <= ST_HALT;
                    end else if (step_pulse) begin
                        // The stepped enable executes the breakpoint instruction itself.
                        cpu_en   <= 1'b1;
                        state_q  <= ST_RUN;
                        tick_cnt <= '0;
                        bp_skip  <= 1'b0;
                        brk_hit  <= 1'b0;
                    end
                end
                ST_SPIN: begin
                    if (!run_lvl) begin
                        state_q <= ST_HALT;
                    end
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Directed bench for td4_exec_ctrl with DIV=4, DEB_CYCLES=3; inputs change and
// outputs are sampled on the falling clock edge.
module tb_td4_exec_ctrl;

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_BRK  = 2'd2;
    localparam logic [1:0] S_SPIN = 2'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run_sw_n = 1'b1;
    logic        step_btn_n = 1'b1;
    logic        bp_en = 1'b0;
    logic [3:0]  bp_addr = 4'h0;
    logic [3:0]  pc = 4'h0;
    logic [7:0]  opcode = 8'h01;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic        brk_hit;
    logic [15:0] instr_count;

    int tests_run = 0;
    int tests_failed = 0;

    td4_exec_ctrl #(.DIV(4), .DEB_CYCLES(3), .CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .run_sw_n    (run_sw_n),
        .step_btn_n  (step_btn_n),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .opcode      (opcode),
        .cpu_en      (cpu_en),
        .state       (state),
        .halted      (halted),
        .brk_hit     (brk_hit),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // Leaves the bench on a falling edge with reset just released; the next
    // rising edge is the first one the design sees out of reset.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        tests_run++;
        if (state !== S_HALT) begin tests_failed++; $display("[TB] FAIL reset_state got %0d want %0d", state, S_HALT); end
        tests_run++;
        if (cpu_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cpu_en got %0b want 0", cpu_en); end
        tests_run++;
        if (brk_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_brk_hit got %0b want 0", brk_hit); end
        tests_run++;
        if (instr_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_count got %0d want 0", instr_count); end
        tests_run++;
        if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_halted got %0b want 1", halted); end
        reset = 1'b0;
    endtask

    task automatic test_run_basic();
        logic [1:0] exp_state;
        logic       exp_en;
        run_sw_n = 1'b1; step_btn_n = 1'b1; bp_en = 1'b0; bp_addr = 4'h0; pc = 4'h0; opcode = 8'h01;
        apply_reset();
        run_sw_n = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clock);
            exp_state = (k >= 6) ? S_RUN : S_HALT;
            exp_en    = (k == 10) || (k == 14) || (k == 18);
            tests_run++;
            if (state !== exp_state) begin tests_failed++; $display("[TB] FAIL run_basic_state k=%0d got %0d want %0d", k, state, exp_state); end
            tests_run++;
            if (cpu_en !== exp_en) begin tests_failed++; $display("[TB] FAIL run_basic_cpu_en k=%0d got %0b want %0b", k, cpu_en, exp_en); end
        end
        tests_run++;
        if (instr_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL run_basic_count got %0d want 3", instr_count); end
        tests_run++;
        if (halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL run_basic_halted got %0b want 0", halted); end
    endtask

    task automatic test_debounce();
        run_sw_n = 1'b1; step_btn_n = 1'b1; bp_en = 1'b0; pc = 4'h0; opcode = 8'h01;
        apply_reset();
        step_btn_n = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clock);
            if (j == 2) step_btn_n = 1'b1;
            tests_run++;
            if (cpu_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL debounce_glitch j=%0d got %0b want 0", j, cpu_en); end
        end
        step_btn_n = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clock);
            if (j == 10) step_btn_n = 1'b1;
            tests_run++;
            if (cpu_en !== (j == 7)) begin tests_failed++; $display("[TB] FAIL debounce_press_cpu_en j=%0d got %0b want %0b", j, cpu_en, (j == 7)); end
            tests_run++;
            if (state !== S_HALT) begin tests_failed++; $display("[TB] FAIL debounce_press_state j=%0d got %0d want %0d", j, state, S_HALT); end
        end
        tests_run++;
        if (instr_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL debounce_count got %0d want 1", instr_count); end
    endtask

    task automatic test_breakpoint();
        run_sw_n = 1'b1; step_btn_n = 1'b1; bp_en = 1'b1; bp_addr = 4'h3; pc = 4'h2; opcode = 8'h01;
        apply_reset();
        run_sw_n = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== (j == 10)) begin tests_failed++; $display("[TB] FAIL bp_run_cpu_en j=%0d got %0b want %0b", j, cpu_en, (j == 10)); end
            if (j == 10) pc = 4'h3;
        end
        tests_run++;
        if (state !== S_BRK) begin tests_failed++; $display("[TB] FAIL bp_state got %0d want %0d", state, S_BRK); end
        tests_run++;
        if (brk_hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_brk_hit got %0b want 1", brk_hit); end
        tests_run++;
        if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_halted got %0b want 1", halted); end
        step_btn_n = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== (j == 7)) begin tests_failed++; $display("[TB] FAIL bp_step_cpu_en j=%0d got %0b want %0b", j, cpu_en, (j == 7)); end
            tests_run++;
            if (state !== ((j == 7) ? S_RUN : S_BRK)) begin tests_failed++; $display("[TB] FAIL bp_step_state j=%0d got %0d", j, state); end
        end
        tests_run++;
        if (brk_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_step_brk_hit got %0b want 0", brk_hit); end
        step_btn_n = 1'b1;
        pc = 4'h4;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== (j == 4)) begin tests_failed++; $display("[TB] FAIL bp_after_step_cpu_en j=%0d got %0b want %0b", j, cpu_en, (j == 4)); end
        end
    endtask

    task automatic test_self_jump();
        run_sw_n = 1'b1; step_btn_n = 1'b1; bp_en = 1'b0; pc = 4'h7; opcode = 8'hF7;
        apply_reset();
        run_sw_n = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL spin_cpu_en j=%0d got %0b want 0", j, cpu_en); end
        end
        tests_run++;
        if (state !== S_SPIN) begin tests_failed++; $display("[TB] FAIL spin_state got %0d want %0d", state, S_SPIN); end
        step_btn_n = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== 1'b0 || state !== S_SPIN) begin tests_failed++; $display("[TB] FAIL spin_step j=%0d got en=%0b st=%0d want en=0 st=%0d", j, cpu_en, state, S_SPIN); end
        end
        step_btn_n = 1'b1;
        run_sw_n = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            @(negedge clock);
            tests_run++;
            if (state !== ((r >= 6) ? S_HALT : S_SPIN)) begin tests_failed++; $display("[TB] FAIL spin_exit_state r=%0d got %0d", r, state); end
        end
    endtask

    task automatic test_resume_bp();
        run_sw_n = 1'b1; step_btn_n = 1'b1; bp_en = 1'b1; bp_addr = 4'h5; pc = 4'h5; opcode = 8'h01;
        apply_reset();
        run_sw_n = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== (j == 10 || j == 14)) begin tests_failed++; $display("[TB] FAIL resume_cpu_en j=%0d got %0b want %0b", j, cpu_en, (j == 10 || j == 14)); end
            if (j == 10) pc = 4'h6;
            if (j == 14) pc = 4'h5;
        end
        tests_run++;
        if (state !== S_BRK) begin tests_failed++; $display("[TB] FAIL resume_brk_state got %0d want %0d", state, S_BRK); end
        run_sw_n = 1'b1;
        repeat (6) @(negedge clock);
        tests_run++;
        if (state !== S_HALT) begin tests_failed++; $display("[TB] FAIL resume_halt_state got %0d want %0d", state, S_HALT); end
        tests_run++;
        if (brk_hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL resume_sticky_brk_hit got %0b want 1", brk_hit); end
        run_sw_n = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== (s == 10)) begin tests_failed++; $display("[TB] FAIL resume_skip_cpu_en s=%0d got %0b want %0b", s, cpu_en, (s == 10)); end
        end
        tests_run++;
        if (state !== S_RUN || brk_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL resume_rerun got st=%0d brk=%0b want st=%0d brk=0", state, brk_hit, S_RUN); end
    endtask

    task automatic test_priority();
        logic [1:0] exp_state;
        run_sw_n = 1'b1; step_btn_n = 1'b1; bp_en = 1'b0; pc = 4'h0; opcode = 8'h01;
        apply_reset();
        run_sw_n = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clock);
            exp_state = (j >= 6 && j < 14) ? S_RUN : S_HALT;
            tests_run++;
            if (state !== exp_state) begin tests_failed++; $display("[TB] FAIL prio_state j=%0d got %0d want %0d", j, state, exp_state); end
            tests_run++;
            if (cpu_en !== (j == 10)) begin tests_failed++; $display("[TB] FAIL prio_cpu_en j=%0d got %0b want %0b", j, cpu_en, (j == 10)); end
            if (j == 8) run_sw_n = 1'b1;
        end
        @(negedge clock);
        tests_run++;
        if (instr_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL prio_count got %0d want 1", instr_count); end
    endtask

    task automatic test_reset_midrun();
        run_sw_n = 1'b1; step_btn_n = 1'b1; bp_en = 1'b0; pc = 4'h0; opcode = 8'h01;
        apply_reset();
        run_sw_n = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clock);
            tests_run++;
            if (cpu_en !== (j == 10)) begin tests_failed++; $display("[TB] FAIL midrun_cpu_en j=%0d got %0b want %0b", j, cpu_en, (j == 10)); end
        end
        tests_run++;
        if (instr_count !== 16'd1 || state !== S_RUN) begin tests_failed++; $display("[TB] FAIL midrun_pre got cnt=%0d st=%0d want cnt=1 st=%0d", instr_count, state, S_RUN); end
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (state !== S_HALT) begin tests_failed++; $display("[TB] FAIL midrun_reset_state got %0d want %0d", state, S_HALT); end
        tests_run++;
        if (cpu_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun_reset_cpu_en got %0b want 0", cpu_en); end
        tests_run++;
        if (instr_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL midrun_reset_count got %0d want 0", instr_count); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_basic();
        test_debounce();
        test_breakpoint();
        test_self_jump();
        test_resume_bp();
        test_priority();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
